// File: rtl/wam_pkg.sv
// Shared encodings and widths for the whack-a-mole round controller.
package wam_pkg;

  localparam int STATE_W = 3;
  localparam int SCORE_W = 12;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_CDOWN  = 3'd1,
    ST_PLAY   = 3'd2,
    ST_PAUSED = 3'd3,
    ST_OVER   = 3'd4
  } state_t;

endpackage

// File: rtl/wam_tick_gen.sv
// One-second prescaler: single-cycle tick every TICK_DIV running cycles.
// load0 restarts the count; the count holds while run is low.
module wam_tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic clr,
  input  logic run,
  input  logic load0,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = run && (cnt == LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (clr || load0) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/wam_round_ctrl.sv
// Round controller: idle/countdown/play/pause/over FSM and game_logic gating.
// Define WAM_HISCORE_EN to build the high-score register and new_hi flag.
module wam_round_ctrl
  import wam_pkg::*;
#(
  parameter int TICK_DIV      = 50_000_000,
  parameter int ROUND_SEC     = 60,
  parameter int COUNTDOWN_SEC = 3
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               btn_start,
  input  logic               btn_pause,
  input  logic [1:0]         diff_sw,
  input  logic [7:0]         tap_in,
  input  logic [SCORE_W-1:0] score,
  output logic               game_clr,
  output logic               game_pause,
  output logic [1:0]         difficulty,
  output logic [7:0]         tap_out,
  output logic [6:0]         time_left,
  output logic [STATE_W-1:0] state,
  output logic [SCORE_W-1:0] hi_score,
  output logic               new_hi
);

  localparam logic [6:0] ROUND_TL = 7'(ROUND_SEC);
  localparam logic [6:0] CDOWN_TL = 7'(COUNTDOWN_SEC);

  state_t st;
  logic   tick;
  logic   run;
  logic   start_go;
  logic   cd_done;
  logic   load0;

  // Start is ignored only during the countdown; everywhere else it (re)starts.
  always_comb begin
    run      = (st == ST_CDOWN) || (st == ST_PLAY);
    start_go = btn_start && (st != ST_CDOWN);
    cd_done  = (st == ST_CDOWN) && tick && (time_left == 7'd1);
    load0    = start_go || cd_done;
  end

  wam_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .clr  (clr),
    .run  (run),
    .load0(load0),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      st         <= ST_IDLE;
      time_left  <= '0;
      difficulty <= '0;
    end else if (start_go) begin
      st         <= ST_CDOWN;
      time_left  <= CDOWN_TL;
      difficulty <= diff_sw;
    end else begin
      case (st)
        ST_CDOWN: begin
          if (tick) begin
            if (time_left == 7'd1) begin
              st        <= ST_PLAY;
              time_left <= ROUND_TL;
            end else begin
              time_left <= time_left - 7'd1;
            end
          end
        end
        ST_PLAY: begin
          // The last tick ends the round even if pause arrives with it.
          if (tick && (time_left == 7'd1)) begin
            st        <= ST_OVER;
            time_left <= '0;
          end else begin
            if (tick) time_left <= time_left - 7'd1;
            if (btn_pause) st <= ST_PAUSED;
          end
        end
        ST_PAUSED: begin
          if (btn_pause) st <= ST_PLAY;
        end
        default: begin
        end
      endcase
    end
  end

  assign state      = st;
  assign game_clr   = (st == ST_IDLE) || (st == ST_CDOWN);
  assign game_pause = (st != ST_PLAY);
  assign tap_out    = (st == ST_PLAY) ? tap_in : '0;

`ifdef WAM_HISCORE_EN
  logic in_over_q;
  logic over_first;
  logic beat;

  // BCD digits are packed most-significant first, so a binary compare orders scores.
  assign over_first = (st == ST_OVER) && !in_over_q;
  assign beat       = over_first && (score > hi_score);

  always_ff @(posedge clk) begin
    if (clr) begin
      in_over_q <= 1'b0;
      hi_score  <= '0;
      new_hi    <= 1'b0;
    end else begin
      in_over_q <= (st == ST_OVER);
      if (beat) hi_score <= score;
      if (start_go) begin
        new_hi <= 1'b0;
      end else if (beat) begin
        new_hi <= 1'b1;
      end
    end
  end
`else
  logic unused_score;

  assign unused_score = ^score;
  assign hi_score     = '0;
  assign new_hi       = 1'b0;
`endif

endmodule
